// File: rtl/if_fetch_unit.sv
// Fetch stage: architectural PC, credit-limited imem reads, FWFT instruction FIFO.
// Optional IF_MISALIGN_TRAP_EN turns a misaligned PC into a single trap entry.
module if_fetch_unit #(
  parameter int                   REG_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_i,
  input  logic [REG_WIDTH-1:0] redirect_pc_i,
  output logic [REG_WIDTH-1:0] pc_o,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [REG_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [REG_WIDTH-1:0] imem_rsp_data,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic [REG_WIDTH-1:0] inst_o,
  output logic [REG_WIDTH-1:0] inst_pc_o,
  output logic                 inst_exc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [REG_WIDTH-1:0] word_t;

  localparam cnt_t  DEPTH_C = cnt_t'(DEPTH);
  localparam ptr_t  P1      = ptr_t'(1);
  localparam word_t PC_INC  = word_t'(4);

  word_t pc_q, pc_d;
  cnt_t  out_q, out_d;
  cnt_t  disc_q, disc_d;
  cnt_t  cnt_q, cnt_d;
  ptr_t  wr_q, wr_d, rd_q, rd_d;
  ptr_t  pw_q, pw_d, pr_q, pr_d;
  word_t inst_q [DEPTH];
  word_t ipc_q  [DEPTH];
  word_t pcq_q  [DEPTH];

  logic  mis, exc_push;
  logic  req_ok, req_fire, rsp_keep, push, pop;
  word_t push_inst, push_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic exc_done_q, exc_done_d;
  logic exc_q [DEPTH];
`endif

  always_comb begin
    mis      = 1'b0;
    exc_push = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    mis      = pc_q[1:0] != 2'b00;
    exc_push = mis && !exc_done_q && !redirect_i &&
               cnt_q == '0 && out_q == '0;
`endif
    req_ok    = rst_n && !redirect_i && !mis &&
                (out_q + cnt_q) < DEPTH_C;
    req_fire  = req_ok && imem_req_ready;
    pop       = cnt_q != '0 && inst_ready_i;
    rsp_keep  = imem_rsp_valid && disc_q == '0 && !redirect_i;
    push      = rsp_keep || exc_push;
    push_inst = exc_push ? '0 : imem_rsp_data;
    push_pc   = exc_push ? pc_q : pcq_q[pr_q];

    pc_d   = pc_q;
    out_d  = out_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
    disc_d = disc_q;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    pw_d   = pw_q;
    pr_d   = pr_q;
`ifdef IF_MISALIGN_TRAP_EN
    exc_done_d = exc_done_q || exc_push;
`endif

    if (redirect_i) begin
      // Everything still in flight belongs to the dead path.
      pc_d   = redirect_pc_i;
      disc_d = out_d;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      pw_d   = '0;
      pr_d   = '0;
`ifdef IF_MISALIGN_TRAP_EN
      exc_done_d = 1'b0;
`endif
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_INC;
        pw_d = pw_q + P1;
      end
      if (imem_rsp_valid && disc_q != '0) disc_d = disc_q - cnt_t'(1);
      if (rsp_keep) pr_d = pr_q + P1;
      if (push) wr_d = wr_q + P1;
      if (pop) rd_d = rd_q + P1;
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      pw_q   <= '0;
      pr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        ipc_q[i]  <= '0;
        pcq_q[i]  <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      pw_q   <= pw_d;
      pr_q   <= pr_d;
      if (req_fire) pcq_q[pw_q] <= pc_q;
      if (push && !redirect_i) begin
        inst_q[wr_q] <= push_inst;
        ipc_q[wr_q]  <= push_pc;
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) exc_q[i] <= 1'b0;
    end else begin
      exc_done_q <= exc_done_d;
      if (push) exc_q[wr_q] <= exc_push;
    end
  end
  assign inst_exc_o = inst_valid_o && exc_q[rd_q];
`else
  assign inst_exc_o = 1'b0;
`endif

  assign pc_o           = pc_q;
  assign imem_req_valid = req_ok;
  assign imem_req_addr  = {pc_q[REG_WIDTH-1:2], 2'b00};
  assign inst_valid_o   = cnt_q != '0;
  assign inst_o         = inst_valid_o ? inst_q[rd_q] : '0;
  assign inst_pc_o      = inst_valid_o ? ipc_q[rd_q] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == DEPTH_C));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit against a stream-level fetch model.
// Model: delivered PCs run +4 from each redirect target; data is a hash of the PC.
module tb_if_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_o;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_exc_o;

  if_fetch_unit #(
    .REG_WIDTH (32),
    .RESET_PC  (RST_PC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .pc_o           (pc_o),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_exc_o     (inst_exc_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_due = -1;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] last_pop_pc = '0;
  logic        last_req_valid = 1'b0;
  logic        last_rsp = 1'b0;
  logic        popped = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    pend_addr.delete();
    pend_due.delete();
    m_pc = RST_PC;
    exp_pc = RST_PC;
    last_due = -1;
    cyc = 0;
  endtask

  // One clock: drive at posedge+1, sample at posedge+2, return at next posedge+1.
  task automatic drive_cycle(input logic redir, input logic [31:0] rpc,
                             input logic rr, input logic dr);
    logic fire;
    logic pop;
    int   d;
    redirect_i = redir;
    redirect_pc_i = rpc;
    imem_req_ready = rr;
    inst_ready_i = dr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = memf(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    total++;
    if (pc_o !== m_pc) begin
      bad++;
      $display("FAIL pc_o cyc=%0d got=%h exp=%h", cyc, pc_o, m_pc);
    end
    fire = imem_req_valid && rr;
    pop = inst_valid_o && dr;
    if (fire) begin
      total++;
      if (imem_req_addr !== {m_pc[31:2], 2'b00}) begin
        bad++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_pc);
      end
    end
    if (redir && imem_req_valid) begin
      bad++;
      $display("FAIL req_in_redirect cyc=%0d got=1 exp=0", cyc);
    end
    if (pop) begin
      total++;
      if (inst_pc_o !== exp_pc || inst_o !== memf(exp_pc) || inst_exc_o !== 1'b0) begin
        bad++;
        $display("FAIL deliver cyc=%0d got pc=%h inst=%h exc=%b exp pc=%h inst=%h exc=0",
                 cyc, inst_pc_o, inst_o, inst_exc_o, exp_pc, memf(exp_pc));
      end
      last_pop_pc = inst_pc_o;
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      exp_pc = rpc;
      m_pc = rpc;
    end else if (fire) begin
      d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_addr.push_back(m_pc);
      pend_due.push_back(d);
      m_pc = m_pc + 32'd4;
    end
    if (pend_addr.size() > DEPTH) begin
      bad++;
      $display("FAIL outstanding cyc=%0d got=%0d max=%0d", cyc, pend_addr.size(), DEPTH);
    end
    last_req_valid = imem_req_valid;
    last_rsp = imem_rsp_valid;
    popped = pop;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_i = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (pc_o !== RST_PC) begin
      bad++;
      $display("FAIL reset_pc got=%h exp=%h", pc_o, RST_PC);
    end
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
    end
    total++;
    if (inst_valid_o !== 1'b0 || inst_o !== '0 || inst_pc_o !== '0 || inst_exc_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_inst got v=%b i=%h pc=%h e=%b exp all 0",
               inst_valid_o, inst_o, inst_pc_o, inst_exc_o);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    lat = 1;
    rand_lat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (i >= 2) begin
        total++;
        if (!popped || last_pop_pc !== 32'(4 * (i - 2))) begin
          bad++;
          $display("FAIL stream cyc=%0d got v=%b pc=%h exp v=1 pc=%h",
                   i, popped, last_pop_pc, 32'(4 * (i - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    int          fires;
    int          n;
    logic [31:0] held;
    fires = 0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      if (last_req_valid) fires++;
      if (i == 5) held = pc_o;
      if (i >= 7) begin
        total++;
        if (last_req_valid !== 1'b0) begin
          bad++;
          $display("FAIL stall_req cyc=%0d got=1 exp=0", i);
        end
      end
    end
    total++;
    if (fires > DEPTH) begin
      bad++;
      $display("FAIL stall_fires got=%0d max=%0d", fires, DEPTH);
    end
    total++;
    if (pc_o !== held) begin
      bad++;
      $display("FAIL stall_pc got=%h exp=%h", pc_o, held);
    end
    n = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (popped) n++;
    end
    total++;
    if (n < DEPTH) begin
      bad++;
      $display("FAIL stall_drain got=%0d exp>=%0d", n, DEPTH);
    end
  endtask

  task automatic test_redirect_outstanding();
    int          fires;
    int          n;
    logic [31:0] got[2];
    fires = 0;
    n = 0;
    got[0] = '0;
    got[1] = '0;
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
    lat = 8;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (last_req_valid) fires++;
    end
    total++;
    if (fires != 2) begin
      bad++;
      $display("FAIL redir_setup got=%0d exp=2", fires);
    end
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b1);
    lat = 1;
    for (int i = 0; i < 40 && n < 2; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (popped) begin
        got[n] = last_pop_pc;
        n++;
      end
    end
    total++;
    if (n != 2 || got[0] !== 32'h100 || got[1] !== 32'h104) begin
      bad++;
      $display("FAIL redir_outstanding got n=%0d %h %h exp 2 00000100 00000104",
               n, got[0], got[1]);
    end
  endtask

  task automatic test_redirect_collision();
    int          n;
    logic [31:0] first;
    n = 0;
    first = '0;
    lat = 1;
    repeat (6) drive_cycle(1'b0, '0, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'h300, 1'b1, 1'b1);
    total++;
    if (last_rsp !== 1'b1 || last_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL collide_cycle got rsp=%b req=%b exp rsp=1 req=0", last_rsp, last_req_valid);
    end
    total++;
    if (pc_o !== 32'h300) begin
      bad++;
      $display("FAIL collide_pc got=%h exp=00000300", pc_o);
    end
    for (int i = 0; i < 20 && n == 0; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (popped) begin
        first = last_pop_pc;
        n++;
      end
    end
    total++;
    if (n != 1 || first !== 32'h300) begin
      bad++;
      $display("FAIL collide_first got n=%0d pc=%h exp 1 00000300", n, first);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcb;
    bit          wrapped;
    wrapped = 1'b0;
    lat = 1;
    drive_cycle(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !wrapped; i++) begin
      pcb = pc_o;
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (last_req_valid && pcb == 32'hFFFF_FFFC) begin
        wrapped = 1'b1;
        total++;
        if (pc_o !== 32'h0) begin
          bad++;
          $display("FAIL wrap_pc got=%h exp=00000000", pc_o);
        end
      end
    end
    total++;
    if (!wrapped) begin
      bad++;
      $display("FAIL wrap_seen got=0 exp=1");
    end
    repeat (8) drive_cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int n;
    n = 0;
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom % 20) == 0, $urandom & 32'hFFFF_FFFC,
                  ($urandom % 4) != 0, ($urandom % 4) != 0);
    end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      if (popped) n++;
    end
    total++;
    if (n < 10) begin
      bad++;
      $display("FAIL random_progress got=%0d exp>=10", n);
    end
    rand_lat = 1'b0;
  endtask

  task automatic test_async_reset();
    repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pc_o !== RST_PC || inst_valid_o !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got pc=%h v=%b req=%b exp pc=%h v=0 req=0",
               pc_o, inst_valid_o, imem_req_valid, RST_PC);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_collision();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
